// File: rtl/scalar_alu.sv
// Scalar ALU: unsigned add, sub, mul and restoring divide on WIDTH-bit operands.
//
// Ports:
//   i_clk     system clock, all state changes on the rising edge
//   reset     synchronous active-low reset
//   i_ready   one-cycle pulse: op_code, a and b are valid (accepted only when idle)
//   op_code   1 add, 2 sub, 3 mul, 4 div; any other code is illegal
//   a, b      unsigned operands
//   o_result  primary result (sum, difference, product low half, quotient)
//   o_rem     secondary result (carry, borrow, product high half, remainder)
//   o_err     divide-by-zero or illegal op_code for the completed operation
//   o_busy    high while an operation is in flight (EXEC, DIV, DONE)
//   o_ready   one-cycle completion pulse, high during DONE
module scalar_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_ready,
  input  logic [7:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_ready
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [7:0] OpAdd = 8'd1;
  localparam logic [7:0] OpSub = 8'd2;
  localparam logic [7:0] OpMul = 8'd3;
  localparam logic [7:0] OpDiv = 8'd4;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDiv, StDone} state_e;

  state_e            state_q;
  logic [7:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  rem_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    sub_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  rem_d;

  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    // Zero-extended subtraction: the top bit is the borrow (a < b).
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits.
    div_shift = {rem_q, quo_q[WIDTH-1]};
    quo_d     = {quo_q[WIDTH-2:0], 1'b0};
    rem_d     = div_shift[WIDTH-1:0];
    if (div_shift >= {1'b0, b_q}) begin
      // Result is below b, so the low WIDTH bits of the difference suffice.
      rem_d    = div_shift[WIDTH-1:0] - b_q;
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      o_result <= '0;
      o_rem    <= '0;
      o_err    <= 1'b0;
      o_busy   <= 1'b0;
      o_ready  <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          o_busy <= 1'b0;
          if (i_ready) begin
            op_q    <= op_code;
            a_q     <= a;
            b_q     <= b;
            o_busy  <= 1'b1;
            state_q <= StExec;
          end
        end

        StExec: begin
          state_q <= StDone;
          o_ready <= 1'b1;
          o_err   <= 1'b0;
          case (op_q)
            OpAdd: begin
              o_result <= add_sum[WIDTH-1:0];
              o_rem    <= {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            end
            OpSub: begin
              o_result <= sub_diff[WIDTH-1:0];
              o_rem    <= {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
            end
            OpMul: begin
              o_result <= prod[WIDTH-1:0];
              o_rem    <= prod[2*WIDTH-1:WIDTH];
            end
            OpDiv: begin
              if (b_q == '0) begin
                o_result <= '1;
                o_rem    <= a_q;
                o_err    <= 1'b1;
              end else begin
                // Outputs keep the previous completion until DIV finishes.
                o_ready  <= 1'b0;
                o_err    <= o_err;
                quo_q    <= a_q;
                rem_q    <= '0;
                cnt_q    <= '0;
                state_q  <= StDiv;
              end
            end
            default: begin
              o_result <= '0;
              o_rem    <= '0;
              o_err    <= 1'b1;
            end
          endcase
        end

        StDiv: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            o_result <= quo_d;
            o_rem    <= rem_d;
            o_err    <= 1'b0;
            o_ready  <= 1'b1;
            state_q  <= StDone;
          end
        end

        StDone: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_alu.sv
// Directed bench for scalar_alu at WIDTH=16. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Latency is the number of
// falling edges from the capture edge to the first one with o_ready high.
module tb_scalar_alu;

  logic        i_clk;
  logic        reset;
  logic        i_ready;
  logic [7:0]  op_code;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] o_result;
  logic [15:0] o_rem;
  logic        o_err;
  logic        o_busy;
  logic        o_ready;

  int n_checks = 0;
  int n_errors = 0;

  scalar_alu #(.WIDTH(16)) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_ready  (i_ready),
    .op_code  (op_code),
    .a        (a),
    .b        (b),
    .o_result (o_result),
    .o_rem    (o_rem),
    .o_err    (o_err),
    .o_busy   (o_busy),
    .o_ready  (o_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents an operation for one capture edge, then scrambles the inputs.
  // Returns on the first falling edge after the capture edge.
  task automatic start_op(input logic [7:0] op, input logic [15:0] aa, input logic [15:0] bb);
    op_code = op;
    a       = aa;
    b       = bb;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    a       = 16'($urandom);
    b       = 16'($urandom);
    op_code = 8'($urandom_range(1, 4));
  endtask

  // Waits for o_ready; lat counts falling edges since capture, bc counts
  // edges with busy high before completion.
  task automatic wait_ready(input int start, output int lat, output int bc);
    lat = start;
    bc  = 0;
    while (!o_ready && lat < 100) begin
      if (o_busy) bc++;
      @(negedge i_clk);
      lat++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [7:0] op, input logic [15:0] aa,
                       input logic [15:0] bb, input logic [15:0] er, input logic [15:0] em,
                       input logic ee, input int el);
    int lat;
    int bc;
    start_op(op, aa, bb);
    wait_ready(1, lat, bc);
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_result"}, 32'(o_result), 32'(er));
    check({tag, "_rem"}, 32'(o_rem), 32'(em));
    check({tag, "_err"}, 32'(o_err), 32'(ee));
    check({tag, "_busy_in_done"}, 32'(o_busy), 32'd1);
    @(negedge i_clk);
    check({tag, "_ready_pulse"}, 32'(o_ready), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_hold"}, 32'(o_result), 32'(er));
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    reset   = 1'b0;
    i_ready = 1'b1;
    op_code = 8'd1;
    a       = 16'd1;
    b       = 16'd1;
    repeat (3) @(negedge i_clk);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_rem", 32'(o_rem), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);

    // First capture on the first edge with reset released.
    reset = 1'b1;
    do_op("add_ovf", 8'd1, 16'hFFFF, 16'h0002, 16'h0001, 16'h0001, 1'b0, 2);
    do_op("sub_borrow", 8'd2, 16'd3, 16'd5, 16'hFFFE, 16'h0001, 1'b0, 2);
    do_op("mul_b2b", 8'd3, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 2);
    do_op("add_plain", 8'd1, 16'h1000, 16'h0234, 16'h1234, 16'h0000, 1'b0, 2);
    do_op("sub_eq", 8'd2, 16'h0077, 16'h0077, 16'h0000, 16'h0000, 1'b0, 2);

    // Divide with busy accounting.
    start_op(8'd4, 16'd1000, 16'd7);
    wait_ready(1, lat, bc);
    check("div_lat", 32'(lat), 32'd18);
    check("div_busy_cycles", 32'(bc), 32'd17);
    check("div_result", 32'(o_result), 32'd142);
    check("div_rem", 32'(o_rem), 32'd6);
    check("div_err", 32'(o_err), 32'd0);
    @(negedge i_clk);

    do_op("div0", 8'd4, 16'h00AA, 16'h0000, 16'hFFFF, 16'h00AA, 1'b1, 2);
    do_op("ill9", 8'd9, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 2);
    do_op("ill0", 8'd0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b1, 2);
    do_op("mul_max", 8'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 2);

    // i_ready during a divide is ignored; old result held while in flight.
    start_op(8'd4, 16'd1000, 16'd7);
    repeat (4) @(negedge i_clk);
    check("inflight_hold", 32'(o_result), 32'h0001);
    op_code = 8'd1;
    a       = 16'd1;
    b       = 16'd1;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    wait_ready(6, lat, bc);
    check("ign_lat", 32'(lat), 32'd18);
    check("ign_result", 32'(o_result), 32'd142);
    check("ign_rem", 32'(o_rem), 32'd6);
    @(negedge i_clk);

    do_op("div_by1", 8'd4, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 18);
    do_op("div_small", 8'd4, 16'd5, 16'd9, 16'h0000, 16'h0005, 1'b0, 18);

    // Abort a divide with reset at cycle 8.
    seen = 0;
    start_op(8'd4, 16'd50000, 16'd3);
    for (int i = 1; i < 8; i++) begin
      if (o_ready) seen++;
      @(negedge i_clk);
    end
    reset = 1'b0;
    @(negedge i_clk);
    reset = 1'b1;
    check("abort_result", 32'(o_result), 32'd0);
    check("abort_rem", 32'(o_rem), 32'd0);
    check("abort_err", 32'(o_err), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 25; i++) begin
      if (o_ready) seen++;
      @(negedge i_clk);
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    do_op("add_after_abort", 8'd1, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scalar_alu.md
SCALAR_ALU -- requirements
Module: scalar_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; low = asserted, sampled on i_clk.
REQ-004 SHALL have port i_ready  input  1  one-cycle pulse marking op_code, a and b valid; driven by the operator decoder.
REQ-005 SHALL have port op_code  input  8  operation select: 1 add, 2 sub, 3 mul, 4 div; all other codes illegal.
REQ-006 SHALL have port a  input  WIDTH  unsigned first operand.
REQ-007 SHALL have port b  input  WIDTH  unsigned second operand.
REQ-008 SHALL have port o_result  output  WIDTH  primary result.
REQ-009 SHALL have port o_rem  output  WIDTH  secondary result: carry, borrow, product high half or remainder.
REQ-010 SHALL have port o_err  output  1  error flag for the completed operation.
REQ-011 SHALL have port o_busy  output  1  high while an operation is in flight.
REQ-012 SHALL have port o_ready  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, EXEC, DIV and DONE.
REQ-014 IDLE with i_ready=1 SHALL capture op_code, a and b into internal registers and go to EXEC; i_ready in any other state SHALL be ignored, with no queuing.
REQ-015 o_busy SHALL be 1 in EXEC, DIV and DONE, and 0 in IDLE.
REQ-016 EXEC SHALL compute add, sub, mul, div-by-zero and illegal-code results in one cycle and go to DONE; a legal div with b!=0 SHALL go to DIV.
REQ-017 Add SHALL set o_result=(a+b) mod 2^WIDTH and o_rem={0..,carry_out}.
REQ-018 Sub SHALL set o_result=(a-b) mod 2^WIDTH and o_rem={0..,borrow}, where borrow=1 iff a<b.
REQ-019 Mul SHALL form the full 2*WIDTH-bit product, with o_result=low half and o_rem=high half.
REQ-020 DIV SHALL perform restoring division at one quotient bit per cycle for exactly WIDTH cycles, then go to DONE with o_result=a/b and o_rem=a%b.
REQ-021 Div with b=0 SHALL skip DIV and set o_result=all ones, o_rem=a, o_err=1.
REQ-022 An illegal op_code SHALL set o_result=0, o_rem=0, o_err=1, with the same latency as add.
REQ-023 o_err SHALL be 0 for every legal, non-zero-divisor operation.
REQ-024 DONE SHALL assert o_ready for exactly one cycle and return to IDLE.
REQ-025 i_ready is accepted on the IDLE cycle immediately after DONE, so back-to-back operations run with one idle cycle between them.
REQ-026 Latency from the capture edge to o_ready high SHALL be 2 cycles for add, sub, mul, div-by-zero and illegal codes, and WIDTH+2 cycles for legal div.
REQ-027 o_result, o_rem and o_err SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-028 Input changes after the capture edge SHALL NOT affect the in-flight operation.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE and set o_result=0, o_rem=0, o_err=0, o_busy=0, o_ready=0.
REQ-030 Reset asserted in EXEC, DIV or DONE SHALL abort the operation without producing an o_ready pulse.
REQ-031 i_ready coincident with asserted reset SHALL be ignored.
REQ-032 The first capture SHALL be possible on the first edge with reset=1.

Verification (WIDTH=16)
REQ-033 Add overflow: a=0xFFFF, b=0x0002, op 1 -> 2 cycles later o_ready=1, o_result=0x0001, o_rem=0x0001, o_err=0.
REQ-034 Sub borrow, then back-to-back mul: a=3, b=5, op 2 -> o_result=0xFFFE, o_rem=1; then a=0x1234, b=0x0100, op 3 on the IDLE cycle after DONE -> o_result=0x3400, o_rem=0x0012.
REQ-035 Divide: a=1000, b=7, op 4 -> o_ready exactly 18 cycles after capture, o_result=142, o_rem=6, o_busy high for 17 cycles.
REQ-036 Errors: op 4 with b=0, a=0x00AA -> o_result=0xFFFF, o_rem=0x00AA, o_err=1, latency 2; op 9 -> o_result=0, o_rem=0, o_err=1.
REQ-037 Busy drop and abort: during a divide, pulse i_ready with op 1 -> ignored, divide result unchanged; start a new divide, assert reset at cycle 8 -> no o_ready, all outputs 0, next add accepted normally.
